// File: rtl/de_stage_if.sv
// ID->EX stage bundle: load/bubble controls, decoded ID fields in, registered E fields out.
interface de_stage_if #(
    parameter int DW     = 32,
    parameter int TNEW_W = 2
);
    logic              en;
    logic              clr;
    logic [DW-1:0]     d_instr;
    logic [DW-1:0]     d_pc;
    logic [DW-1:0]     d_rs_data;
    logic [DW-1:0]     d_rt_data;
    logic [DW-1:0]     d_imm;
    logic [4:0]        d_write_reg;
    logic              d_reg_write_en;
    logic [TNEW_W-1:0] d_tnew;
    logic [DW-1:0]     e_instr;
    logic [DW-1:0]     e_pc;
    logic [DW-1:0]     e_rs_data;
    logic [DW-1:0]     e_rt_data;
    logic [DW-1:0]     e_imm;
    logic [4:0]        e_write_reg;
    logic              e_reg_write_en;
    logic [TNEW_W-1:0] e_tnew;
    logic              e_valid;

    modport master (
        output en, clr, d_instr, d_pc, d_rs_data, d_rt_data, d_imm,
               d_write_reg, d_reg_write_en, d_tnew,
        input  e_instr, e_pc, e_rs_data, e_rt_data, e_imm,
               e_write_reg, e_reg_write_en, e_tnew, e_valid
    );

    modport slave (
        input  en, clr, d_instr, d_pc, d_rs_data, d_rt_data, d_imm,
               d_write_reg, d_reg_write_en, d_tnew,
        output e_instr, e_pc, e_rs_data, e_rt_data, e_imm,
               e_write_reg, e_reg_write_en, e_tnew, e_valid
    );
endinterface

// File: rtl/de_stage_reg.sv
// ID->EX pipeline register: load, bubble on clr, hold with T_new ripening.
// Optional bubble counter enabled by defining DE_BUBBLE_CNT_EN.
module de_stage_reg #(
    parameter int DW     = 32,
    parameter int TNEW_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    de_stage_if.slave        bus,
    output logic [CNT_W-1:0] bubble_cnt
);
    localparam logic [DW-1:0] RST_PC = DW'(32'h0000_3000);

    logic [DW-1:0]     instr_q;
    logic [DW-1:0]     pc_q;
    logic [DW-1:0]     rs_q;
    logic [DW-1:0]     rt_q;
    logic [DW-1:0]     imm_q;
    logic [4:0]        wr_q;
    logic              rwe_q;
    logic [TNEW_W-1:0] tnew_q;
    logic              valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
            pc_q    <= RST_PC;
            rs_q    <= '0;
            rt_q    <= '0;
            imm_q   <= '0;
            wr_q    <= '0;
            rwe_q   <= 1'b0;
            tnew_q  <= '0;
            valid_q <= 1'b0;
        end else if (bus.clr) begin
            // bubble keeps the PC so exception/branch logic still sees an address
            instr_q <= '0;
            pc_q    <= bus.d_pc;
            rs_q    <= '0;
            rt_q    <= '0;
            imm_q   <= '0;
            wr_q    <= '0;
            rwe_q   <= 1'b0;
            tnew_q  <= '0;
            valid_q <= 1'b0;
        end else if (bus.en) begin
            instr_q <= bus.d_instr;
            pc_q    <= bus.d_pc;
            rs_q    <= bus.d_rs_data;
            rt_q    <= bus.d_rt_data;
            imm_q   <= bus.d_imm;
            wr_q    <= bus.d_write_reg;
            rwe_q   <= bus.d_reg_write_en && (bus.d_write_reg != 5'd0);
            tnew_q  <= bus.d_tnew;
            valid_q <= 1'b1;
        end else if (tnew_q != '0) begin
            tnew_q  <= tnew_q - TNEW_W'(1);
        end
    end

    assign bus.e_instr        = instr_q;
    assign bus.e_pc           = pc_q;
    assign bus.e_rs_data      = rs_q;
    assign bus.e_rt_data      = rt_q;
    assign bus.e_imm          = imm_q;
    assign bus.e_write_reg    = wr_q;
    assign bus.e_reg_write_en = rwe_q;
    assign bus.e_tnew         = tnew_q;
    assign bus.e_valid        = valid_q;

`ifdef DE_BUBBLE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt_q <= '0;
        else if (bus.clr) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign bubble_cnt = cnt_q;
`else
    assign bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_de_stage_reg.sv
// Directed + random bench for de_stage_reg with an expected-value scoreboard queue.
module tb_de_stage_reg;
    typedef struct {
        logic [31:0] instr, pc, rs, rt, imm;
        logic [4:0]  wr;
        logic        rwe;
        logic [1:0]  tnew;
        logic        valid;
        logic [1:0]  cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] bubble_cnt;
    int         n_tests = 0;
    int         n_fail  = 0;
    exp_t       m;
    exp_t       sb[$];

    de_stage_if #(.DW(32), .TNEW_W(2)) bus ();

    de_stage_reg #(.DW(32), .TNEW_W(2), .CNT_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk("e_instr",        bus.e_instr,                e.instr);
        chk("e_pc",           bus.e_pc,                   e.pc);
        chk("e_rs_data",      bus.e_rs_data,              e.rs);
        chk("e_rt_data",      bus.e_rt_data,              e.rt);
        chk("e_imm",          bus.e_imm,                  e.imm);
        chk("e_write_reg",    32'(bus.e_write_reg),       32'(e.wr));
        chk("e_reg_write_en", 32'(bus.e_reg_write_en),    32'(e.rwe));
        chk("e_tnew",         32'(bus.e_tnew),            32'(e.tnew));
        chk("e_valid",        32'(bus.e_valid),           32'(e.valid));
        chk("bubble_cnt",     32'(bubble_cnt),            32'(e.cnt));
    endtask

    function automatic exp_t reset_model();
        exp_t r;
        r.instr = '0; r.pc = 32'h0000_3000; r.rs = '0; r.rt = '0; r.imm = '0;
        r.wr = '0; r.rwe = 1'b0; r.tnew = '0; r.valid = 1'b0; r.cnt = '0;
        return r;
    endfunction

    // drive at negedge, predict, push; pop and compare 1 time unit after the posedge
    task automatic step(input logic en, input logic clr, input logic [31:0] instr,
                        input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] imm, input logic [4:0] wr, input logic rwe,
                        input logic [1:0] tn);
        exp_t e;
        @(negedge clk);
        bus.en = en; bus.clr = clr; bus.d_instr = instr; bus.d_pc = pc;
        bus.d_rs_data = rs; bus.d_rt_data = rt; bus.d_imm = imm;
        bus.d_write_reg = wr; bus.d_reg_write_en = rwe; bus.d_tnew = tn;
        if (clr) begin
            m.instr = '0; m.pc = pc; m.rs = '0; m.rt = '0; m.imm = '0;
            m.wr = '0; m.rwe = 1'b0; m.tnew = '0; m.valid = 1'b0;
`ifdef DE_BUBBLE_CNT_EN
            m.cnt = m.cnt + 2'd1;
`endif
        end else if (en) begin
            m.instr = instr; m.pc = pc; m.rs = rs; m.rt = rt; m.imm = imm;
            m.wr = wr; m.rwe = rwe && (wr != 5'd0); m.tnew = tn; m.valid = 1'b1;
        end else if (m.tnew != 2'd0) begin
            m.tnew = m.tnew - 2'd1;
        end
        sb.push_back(m);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk_all(e);
        end
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        m = reset_model();
        chk("rst_e_instr", bus.e_instr, 32'h0);
        chk("rst_e_pc",    bus.e_pc,    32'h0000_3000);
        chk("rst_e_valid", 32'(bus.e_valid), 32'h0);
        chk_all(m);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] cnt_exp [5];
        m = reset_model();
        rst_n = 1'b0;
        bus.en = 1'b0; bus.clr = 1'b0; bus.d_instr = '0; bus.d_pc = '0;
        bus.d_rs_data = '0; bus.d_rt_data = '0; bus.d_imm = '0;
        bus.d_write_reg = '0; bus.d_reg_write_en = 1'b0; bus.d_tnew = '0;
        #12;
        chk("por_e_pc",    bus.e_pc, 32'h0000_3000);
        chk("por_e_valid", 32'(bus.e_valid), 32'h0);
        chk_all(m);
        @(negedge clk);
        rst_n = 1'b1;

        // load: ori $1,$1,5
        step(1, 0, 32'h3421_0005, 32'h0000_3000, 32'h11, 32'h22, 32'h5, 5'd1, 1, 2'd1);
        chk("load_instr", bus.e_instr, 32'h3421_0005);
        chk("load_valid", 32'(bus.e_valid), 32'h1);
        chk("load_tnew",  32'(bus.e_tnew), 32'h1);

        // bubble while en=1
        step(1, 1, 32'hDEAD_BEEF, 32'h0000_3008, 32'h1, 32'h2, 32'h3, 5'd7, 1, 2'd2);
        chk("bub_instr", bus.e_instr, 32'h0);
        chk("bub_wr",    32'(bus.e_write_reg), 32'h0);
        chk("bub_rwe",   32'(bus.e_reg_write_en), 32'h0);
        chk("bub_valid", 32'(bus.e_valid), 32'h0);
        chk("bub_pc",    bus.e_pc, 32'h0000_3008);

        // lw then hold 3 edges: T_new ripens 2,1,0,0
        step(1, 0, 32'h8C28_0004, 32'h0000_300C, 32'hA, 32'hB, 32'h4, 5'd8, 1, 2'd2);
        chk("hold_tnew0", 32'(bus.e_tnew), 32'h2);
        step(0, 0, 32'h1234_5678, 32'h0000_4000, 32'h9, 32'h9, 32'h9, 5'd9, 0, 2'd3);
        chk("hold_tnew1", 32'(bus.e_tnew), 32'h1);
        step(0, 0, 32'h1234_5678, 32'h0000_4004, 32'h9, 32'h9, 32'h9, 5'd9, 0, 2'd3);
        chk("hold_tnew2", 32'(bus.e_tnew), 32'h0);
        step(0, 0, 32'h1234_5678, 32'h0000_4008, 32'h9, 32'h9, 32'h9, 5'd9, 0, 2'd3);
        chk("hold_tnew3", 32'(bus.e_tnew), 32'h0);
        chk("hold_instr", bus.e_instr, 32'h8C28_0004);
        chk("hold_pc",    bus.e_pc, 32'h0000_300C);

        // writes to $0 never advertised
        step(1, 0, 32'h3400_0001, 32'h0000_3010, 32'h0, 32'h0, 32'h1, 5'd0, 1, 2'd1);
        chk("zero_rwe", 32'(bus.e_reg_write_en), 32'h0);

        // clr with en=0 still bubbles
        step(0, 1, 32'hFFFF_FFFF, 32'h0000_3014, 32'h1, 32'h1, 32'h1, 5'd3, 1, 2'd1);
        chk("clr_noen_valid", 32'(bus.e_valid), 32'h0);

        // reset mid-stream, then bubble counter wrap
        mid_reset();
`ifdef DE_BUBBLE_CNT_EN
        cnt_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
`else
        cnt_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 32'h0, 32'h0000_3000 + 32'(4 * i), 32'h0, 32'h0, 32'h0, 5'd0, 0, 2'd0);
            chk("bubble_cnt_seq", 32'(bubble_cnt), 32'(cnt_exp[i]));
        end

        // random mix against the scoreboard model
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                 $urandom, $urandom, $urandom, $urandom, $urandom,
                 5'($urandom_range(0, 31)), 1'($urandom), 2'($urandom_range(0, 3)));
        end

        mid_reset();
        step(1, 0, 32'h0C00_0C00, 32'h0000_3000, 32'h5, 32'h6, 32'h7, 5'd31, 1, 2'd0);
        chk("post_rst_valid", 32'(bus.e_valid), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule
